// File: rtl/edsac_digit_timer.sv
// EDSAC master digit-pulse and minor-cycle timer.
// Generates the d0..d35 framing pulses and tracks which tank minor cycle is emerging.
module edsac_digit_timer #(
    parameter int DIGITS       = 36,
    parameter int MINOR_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    output logic       d0,
    output logic       d2,
    output logic       d7,
    output logic       d17,
    output logic       d18,
    output logic       d20,
    output logic       d25,
    output logic       d35,
    output logic [5:0] dig,
    output logic [3:0] mc,
    output logic       major,
    output logic       active
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [5:0] LAST_DIG = 6'(DIGITS - 1);
    localparam logic [3:0] LAST_MC  = 4'(MINOR_CYCLES - 1);

    logic [0:0] state;
    logic [5:0] dig_q;
    logic [3:0] mc_q;
    logic       single;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            dig_q  <= '0;
            mc_q   <= '0;
            single <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run || step) begin
                        state  <= RUN;
                        dig_q  <= '0;
                        single <= ~run;
                    end
                end
                RUN: begin
                    if (dig_q == LAST_DIG) begin
                        dig_q  <= '0;
                        mc_q   <= (mc_q == LAST_MC) ? '0 : mc_q + 4'd1;
                        single <= 1'b0;
                        // Stops only here, so every started word runs through d35.
                        if (single || !run) begin
                            state <= IDLE;
                        end
                    end else begin
                        dig_q <= dig_q + 6'd1;
                        if (run) begin
                            single <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active = (state == RUN);
    assign dig    = dig_q;
    assign mc     = mc_q;

    assign d0    = active && (dig_q == 6'd0);
    assign d2    = active && (dig_q == 6'd2);
    assign d7    = active && (dig_q == 6'd7);
    assign d17   = active && (dig_q == 6'd17);
    assign d18   = active && (dig_q == 6'd18);
    assign d20   = active && (dig_q == 6'd20);
    assign d25   = active && (dig_q == 6'd25);
    assign d35   = active && (dig_q == 6'd35);
    assign major = d0 && (mc_q == 4'd0);

endmodule

// File: tb/tb_edsac_digit_timer.sv
// Randomized and directed self-checking bench for edsac_digit_timer.
// A clock-count model predicts every output; directed scenarios pin it with literals.
module tb_edsac_digit_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       d0, d2, d7, d17, d18, d20, d25, d35;
    logic [5:0] dig;
    logic [3:0] mc;
    logic       major, active;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam int PD [8] = '{0, 2, 7, 17, 18, 20, 25, 35};
    logic [7:0] pulses;
    assign pulses = {d35, d25, d20, d18, d17, d7, d2, d0};

    edsac_digit_timer #(.DIGITS(36), .MINOR_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .d0(d0), .d2(d2), .d7(d7), .d17(d17), .d18(d18), .d20(d20),
        .d25(d25), .d35(d35), .dig(dig), .mc(mc), .major(major), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: position in the run is a plain clock count since start.
    bit m_active;
    int m_t, m_mc0, m_mc_idle;
    bit m_single;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_t = 0; m_mc0 = 0; m_mc_idle = 0; m_single = 0;
        end else if (!m_active) begin
            if (run || step) begin
                m_active = 1; m_t = 0; m_mc0 = m_mc_idle; m_single = !run;
            end
        end else begin
            bit stop;
            stop = (m_t % 36 == 35) && (m_single || !run);
            if (run || (m_t % 36 == 35)) m_single = 0;
            m_t++;
            if (stop) begin
                m_active = 0;
                m_mc_idle = (m_mc0 + m_t / 36) % 16;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int e_dig, e_mc;
            e_dig = m_active ? m_t % 36 : 0;
            e_mc  = m_active ? (m_mc0 + m_t / 36) % 16 : m_mc_idle;
            check("active", active, m_active);
            check("dig", dig, e_dig);
            check("mc", mc, e_mc);
            check("major", major, m_active && e_dig == 0 && e_mc == 0);
            for (int i = 0; i < 8; i++)
                check($sformatf("d%0d", PD[i]), pulses[i], m_active && e_dig == PD[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dig(input int v, input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            if (active && dig == v) begin found = 1; break; end
            tick();
        end
        check($sformatf("wait_dig%0d_in_time", v), found, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            if (!active) begin found = 1; break; end
            tick();
        end
        check("wait_idle_in_time", found, 1);
    endtask

    initial begin
        int majors [$];
        int n, act_clks;
        int cnt [8];

        #1;
        check("rst_active", active, 0);
        check("rst_dig", dig, 0);
        check("rst_mc", mc, 0);
        check("rst_pulses", pulses, 0);
        tick();
        rst = 0;
        tick();

        // Free-run, recording major pulses by clock number after start.
        run = 1;
        for (int i = 1; i <= 1200; i++) begin
            tick();
            if (major) majors.push_back(i);
        end
        check("major_count", majors.size(), 3);
        if (majors.size() == 3) begin
            check("major_0", majors[0], 1);
            check("major_1", majors[1], 577);
            check("major_2", majors[2], 1153);
        end

        // Graceful stop dropped at dig 5.
        wait_dig(5, 40);
        run = 0;
        n = 0;
        for (int i = 0; i < 40 && !d35; i++) begin tick(); n++; end
        check("stop_d35_delay", n, 30);
        tick();
        check("stop_active", active, 0);

        // Three single steps from reset bring mc to 3.
        rst = 1; tick(); rst = 0; tick();
        for (int k = 0; k < 3; k++) begin
            step = 1; tick(); step = 0;
            wait_idle(50);
        end
        check("mc_after_3_steps", mc, 3);

        step = 1; tick(); step = 0;
        act_clks = 0;
        foreach (cnt[i]) cnt[i] = 0;
        for (int g = 0; g < 50 && active; g++) begin
            act_clks++;
            for (int i = 0; i < 8; i++) cnt[i] += pulses[i];
            tick();
        end
        check("step_active_clks", act_clks, 36);
        for (int i = 0; i < 8; i++) check($sformatf("step_d%0d_once", PD[i]), cnt[i], 1);
        check("step_mc_after", mc, 4);

        // Step upgraded to free-run at dig 10.
        step = 1; tick(); step = 0;
        wait_dig(10, 40);
        run = 1;
        wait_dig(35, 40);
        tick();
        check("upgrade_d0", d0, 1);
        check("upgrade_active", active, 1);
        check("upgrade_mc", mc, 5);
        run = 0;
        wait_idle(50);

        // Simultaneous run and step, run dropped after 100 clks.
        run = 1; step = 1; tick(); step = 0;
        act_clks = 1;
        repeat (99) begin tick(); if (active) act_clks++; end
        run = 0;
        for (int g = 0; g < 50; g++) begin
            tick();
            if (!active) break;
            act_clks++;
        end
        check("simul_active_clks", act_clks, 108);

        // Asynchronous reset mid-run at dig 20.
        run = 1; tick();
        wait_dig(20, 40);
        #2 rst = 1;
        #1;
        check("arst_active", active, 0);
        check("arst_dig", dig, 0);
        check("arst_mc", mc, 0);
        check("arst_pulses", pulses, 0);
        check("arst_major", major, 0);
        run = 0;
        tick();
        rst = 0;
        repeat (5) tick();
        check("post_rst_idle", active, 0);

        // Randomized run/step traffic against the model.
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            step = ($urandom_range(0, 19) == 0);
            tick();
        end
        run = 0; step = 0;
        wait_idle(50);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/edsac_digit_timer.md
# edsac_digit_timer

Master digit-pulse and minor-cycle timer for the EDSAC control section. It generates the one-clock digit pulses d0–d35 that every control unit uses to frame words in circulation. That includes the d0/d2/d7/d18/d20/d25 pulses consumed by the coincidence unit and the d17/d35 word-end pulses. It also tracks which of the 16 minor cycles of a memory tank is currently emerging. Start and stop requests take effect only on minor-cycle boundaries, so downstream units never see a truncated word.

## Interface
Parameters:
- DIGITS, 36, digit positions per minor cycle (pulse ports below are fixed for 36; other values are for simulation only).
- MINOR_CYCLES, 16, minor cycles per tank circulation (power of two).

Ports:
- clk  input  1  system clock; one clk = one pulse interval (p.i.).
- rst  input  1  reset, asynchronous, active-high.
- run  input  1  level; 1 = free-run the timer, 0 = stop at the next minor-cycle end.
- step  input  1  one-clk pulse; while stopped, runs exactly one minor cycle.
- d0, d2, d7, d17, d18, d20, d25, d35  output  1 each  digit pulses; dN is high for exactly one clk when the timer is active and the digit count equals N.
- dig  output  6  current digit index, 0..35.
- mc  output  4  current minor-cycle index, 0..15.
- major  output  1  high for one clk at d0 of minor cycle 0.
- active  output  1  high while the timer is in RUN state.

## Operation
- States: IDLE, RUN.
- IDLE: all digit pulses and `major` are 0; `dig` holds 0; `mc` holds its value.
- IDLE→RUN: at a clk edge where `run`=1 or `step`=1. The first active clk shows dig=0 and d0=1.
- `step` latches a one-minor-cycle flag (`single`) when it is accepted in IDLE. `step` is ignored in RUN.
- RUN, each clk:
  - dig<35: dig += 1.
  - dig==35: dig → 0 and mc → (mc+1) mod 16.
- RUN→IDLE: only at the edge ending the dig==35 clk, when (`run`=0 and not `single`) or `single`=1.
  - `single` clears on the same edge.
  - mc still increments on that edge, so it points at the next minor cycle to emerge.
- Dropping `run` mid-cycle completes the current minor cycle; d35 is always emitted.
- Raising `run` during a `single` cycle converts it to free-run: `single` is cleared and the timer does not stop at d35.
- If `run`=1 and `step`=1 arrive on the same edge in IDLE, the timer enters free-run (`run` dominates).
- Pulse decode: dN = active & (dig==N). `major` = active & dig==0 & mc==0. All outputs are registered state or decodes of registered state; there is no combinational path from `run`/`step` to any output.

## Timing
- Reset values:
  - state IDLE, dig=0, mc=0, single=0.
  - d0–d35=0, major=0, active=0.
- `rst` acts asynchronously; an assert mid-cycle immediately forces all pulses low.
- Start latency: `run` sampled high at edge k gives active=1, d0=1 in the clk after edge k.
- Period in RUN: d0 repeats every 36 clks; `major` repeats every 576 clks.
- Within one minor cycle, pulse order and spacing are fixed: d0, d2 (+2), d7 (+7), d17 (+17), d18 (+18), d20 (+20), d25 (+25), d35 (+35). Each pulse appears exactly once.
- Stop latency: between 1 and 36 clks after `run` falls, always ending right after a d35 clk.
- Back-to-back minor cycles: in RUN, the clk after d35 is d0 with no gap.

## Test plan
- Reset check: assert `rst` mid-run at dig=20 → all pulses 0, dig=0, mc=0, active=0 in the same clk. Release `rst` with run=0 → the timer stays idle.
- Free-run: hold run=1 for 1200 clks → d0 every 36 clks; d18 exactly 18 clks after each d0; mc steps 0..15 and wraps; `major` pulses at clk 1, 577 and 1153 after start.
- Graceful stop: drop `run` when dig=5 → d35 still appears 30 clks later. active=0 on the following clk, mc incremented by 1, no further pulses.
- Single step: in IDLE with mc=3, pulse `step` once → exactly 36 active clks with one of each pulse. Timer returns to IDLE with mc=4.
- Step upgraded to run: pulse `step`, then raise `run` at dig=10 → no stop at d35; the next clk is d0 with mc+1.
- Simultaneous `run`=1 and `step`=1 in IDLE, then `run` dropped after 100 clks → the timer stops at the first d35 after the drop, not after the first minor cycle.
